ldq_dram_fetch: RTL and testbench
=================================

# ldq_dram_fetch

Load-queue fetch stage directly upstream of the radix-sort input stage. Issues sequential line-read requests to DRAM, buffers in-order responses in a credit-protected FIFO, and presents one LDQ line per enabled cycle on `ldq_data` / `ldq_data_valid`. It honours the same stall rule as the downstream sort pipeline: it advances only when `mode == MODE_WORK && unit_en`.

## Interface
- `LDQ_DATA_WIDTH`, default `` `LDQ_DATA_WIDTH ``: bits per DRAM line; equals STREAM_WIDTH × (BITS_ROW_IDX + DATA_PRECISION).
- `DEPTH`, default 16: FIFO entries; power of two, ≥ 4.
- `LOG_DEPTH`, default 4: log2(DEPTH).
- `ADDR_WIDTH`, default 32: DRAM line-address width.
- `LEN_WIDTH`, default 24: width of the line-count field.
- Clock and reset: one clock, `clk`; reset `rst_b` is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_b`  in  1  asynchronous active-low reset.
- `unit_en`  in  1  unit enable.
- `mode`  in  1  `MODE_WORK` enables streaming.
- `start`  in  1  single-cycle pulse; latches `base_addr` and `num_lines`.
- `base_addr`  in  ADDR_WIDTH  first line address.
- `num_lines`  in  LEN_WIDTH  number of lines to fetch.
- `rd_req_valid`  out  1  read request valid.
- `rd_req_addr`  out  ADDR_WIDTH  line address.
- `rd_req_ready`  in  1  DRAM accepts the request.
- `rd_rsp_valid`  in  1  in-order response beat; no backpressure.
- `rd_rsp_data`  in  LDQ_DATA_WIDTH  response line.
- `ldq_data_valid`  out  1  line valid toward the sort stage.
- `ldq_data`  out  LDQ_DATA_WIDTH  line; MSB chunk holds the lowest-index element, passed unmodified.
- `busy`  out  1  job in progress.
- `done`  out  1  sticky; job fully emitted.
- `err_rsp`  out  1  sticky; unexpected response or FIFO overflow.

## Operation
- Define `en = (mode == MODE_WORK) && unit_en`.
- FSM states: IDLE, FETCH, DRAIN, FIN.
  - IDLE: on `start`, latch `addr <= base_addr`, `req_left <= num_lines`, `rsp_left <= num_lines`; clear `done`.
    - If `num_lines == 0`, go to FIN.
    - Otherwise go to FETCH.
  - FETCH: `rd_req_valid = (req_left != 0) && (occ + outstanding < DEPTH)`; `rd_req_addr = addr`.
    - On a request handshake: `addr++`, `req_left--`, `outstanding++`.
    - When `req_left` reaches 0, go to DRAIN.
  - DRAIN: wait until `rsp_left == 0`, the FIFO is empty, and the output register has issued the last line; then go to FIN.
  - FIN: `done = 1`, go to IDLE. `done` stays high until the next `start`.
- Responses:
  - Each `rd_rsp_valid` pushes `rd_rsp_data` into the FIFO, decrements `outstanding` and `rsp_left`, and is accepted regardless of `en`.
  - A response in IDLE/FIN, or with `outstanding == 0`, is dropped and sets `err_rsp`.
  - A push while the FIFO is full sets `err_rsp` and drops the data. The credit rule makes this unreachable.
  - A request handshake and a response in the same cycle leave `outstanding` unchanged.
- Output register: updates only when `en`.
  - `ldq_data_valid <= !empty`.
  - If not empty: `ldq_data <= head` and pop.
  - When `en` is 0, both outputs hold their values; no pop.
- Same-cycle push and pop: `occ` is unchanged. A push into an empty FIFO is not visible at the head until the next cycle.
- Pointers: `wr_ptr` and `rd_ptr` are LOG_DEPTH+1 bits and wrap modulo 2·DEPTH. `occ = wr_ptr - rd_ptr`.
- Counter widths:
  - `outstanding` is LOG_DEPTH+1 bits.
  - `req_left` and `rsp_left` are LEN_WIDTH bits.
  - `addr` wraps modulo 2^ADDR_WIDTH.
- `start` while `busy` is ignored.
- `busy` = state ∈ {FETCH, DRAIN}.

## Timing
- Reset values: `rd_req_valid = 0`, `rd_req_addr = 0`, `ldq_data_valid = 0`, `ldq_data = 0`, `busy = 0`, `done = 0`, `err_rsp = 0`, state IDLE. Pointers and counters are 0.
- Reset asserted mid-job: all state clears immediately. Responses that arrive afterward fall in IDLE and set `err_rsp`.
- First request is valid in the cycle after the `start` edge.
- Latency with `en = 1` throughout:
  - response accepted at edge E0;
  - head valid after E0;
  - `ldq_data_valid` high after edge E0+1.
- Sustained throughput: one line per cycle when DRAM round-trip latency < DEPTH.
- `done` rises one edge after the DRAIN exit condition.
- `rd_req_valid` must not depend combinationally on `rd_req_ready`.

## Test plan
- Basic job: `start`, `base_addr = 0x100`, `num_lines = 4`, DRAM latency 3, `en = 1`.
  - Requests go to 0x100–0x103 on consecutive cycles.
  - 4 `ldq_data_valid` pulses carry the data in order.
  - `done` rises after the last line; `err_rsp = 0`.
- Credit limit: `DEPTH = 16`, `num_lines = 40`, `en = 0` for the first 30 cycles.
  - Exactly 16 requests are issued, then `rd_req_valid = 0`.
  - After `en = 1`, all 40 lines emerge in order with no overflow.
- Stall mid-stream: `num_lines = 8`, toggle `en` every 2 cycles.
  - `ldq_data_valid` and `ldq_data` hold while `en = 0`.
  - No line is lost or duplicated; the output count is 8.
- Zero-length job: `num_lines = 0`.
  - No requests are issued; `done = 1` two edges after `start`.
- Error and reset: a spurious `rd_rsp_valid` in IDLE sets `err_rsp`, which stays set.
  - Assert `rst_b = 0` mid-job.
  - All outputs read 0 asynchronously; a new job afterward runs correctly.
- Ready backpressure: hold `rd_req_ready = 0` for 5 cycles with `num_lines = 3`.
  - `rd_req_addr` stays stable at `base_addr` while waiting.
  - 3 handshakes complete in total.

Source files
------------

// File: rtl/ldq_dram_fetch_if.sv
// DRAM line-read bus between the LDQ fetch stage (master) and the memory
// model/controller (slave): request channel with ready, in-order response beats.
`timescale 1ns/1ps
`ifndef LDQ_DATA_WIDTH
`define LDQ_DATA_WIDTH 64
`endif

interface ldq_dram_fetch_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LDQ_DATA_WIDTH = `LDQ_DATA_WIDTH
);
  logic                      rd_req_valid;
  logic [ADDR_WIDTH-1:0]     rd_req_addr;
  logic                      rd_req_ready;
  logic                      rd_rsp_valid;
  logic [LDQ_DATA_WIDTH-1:0] rd_rsp_data;

  modport master (
    output rd_req_valid, rd_req_addr,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data
  );

  modport slave (
    input  rd_req_valid, rd_req_addr,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data
  );
endinterface

// File: rtl/ldq_dram_fetch.sv
// LDQ fetch stage: issues sequential DRAM line reads under a FIFO credit limit
// and streams buffered responses to the sort stage one line per enabled cycle.
`timescale 1ns/1ps
`ifndef LDQ_DATA_WIDTH
`define LDQ_DATA_WIDTH 64
`endif

module ldq_dram_fetch #(
  parameter int LDQ_DATA_WIDTH = `LDQ_DATA_WIDTH,
  parameter int DEPTH          = 16,
  parameter int LOG_DEPTH      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int LEN_WIDTH      = 24
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      unit_en,
  input  logic                      mode,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [LEN_WIDTH-1:0]      num_lines,
  ldq_dram_fetch_if.master          dram,
  output logic                      ldq_data_valid,
  output logic [LDQ_DATA_WIDTH-1:0] ldq_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err_rsp
);
  localparam logic MODE_WORK = 1'b1;
  localparam int   PW        = LOG_DEPTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW:0]   DEPTH_W = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  state_t                    state, state_nxt;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [LEN_WIDTH-1:0]      req_left, rsp_left;
  logic [PW-1:0]             outstanding, wr_ptr, rd_ptr, occ;
  logic [LDQ_DATA_WIDTH-1:0] mem [DEPTH];
  logic                      en, empty, full, credit;
  logic                      req_hs, rsp_ok, push, start_ok;

  assign en       = (mode == MODE_WORK) && unit_en;
  assign occ      = wr_ptr - rd_ptr;
  assign empty    = (occ == '0);
  assign full     = (occ == DEPTH_P);
  // Lines in the FIFO plus lines still in flight may never exceed the FIFO size.
  assign credit   = ({1'b0, occ} + {1'b0, outstanding}) < DEPTH_W;
  assign start_ok = start && (state == IDLE);
  assign rsp_ok   = dram.rd_rsp_valid && (state == FETCH || state == DRAIN) &&
                    (outstanding != '0);
  assign push     = rsp_ok && !full;
  assign req_hs   = dram.rd_req_valid && dram.rd_req_ready;

  always_comb begin
    state_nxt         = state;
    dram.rd_req_valid = 1'b0;
    dram.rd_req_addr  = addr;
    busy              = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (num_lines == '0) ? FIN : FETCH;
      FETCH: begin
        busy              = 1'b1;
        dram.rd_req_valid = (req_left != '0) && credit;
        if (req_left == '0 || (req_hs && req_left == LEN_WIDTH'(1)))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (rsp_left == '0 && empty) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state          <= IDLE;
      addr           <= '0;
      req_left       <= '0;
      rsp_left       <= '0;
      outstanding    <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ldq_data_valid <= 1'b0;
      ldq_data       <= '0;
      done           <= 1'b0;
      err_rsp        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        addr     <= base_addr;
        req_left <= num_lines;
        rsp_left <= num_lines;
        done     <= 1'b0;
      end
      if (req_hs) begin
        addr     <= addr + ADDR_WIDTH'(1);
        req_left <= req_left - LEN_WIDTH'(1);
      end
      if (rsp_ok) rsp_left <= rsp_left - LEN_WIDTH'(1);
      case ({req_hs, rsp_ok})
        2'b10:   outstanding <= outstanding + PW'(1);
        2'b01:   outstanding <= outstanding - PW'(1);
        default: outstanding <= outstanding;
      endcase
      if (state == FIN) done <= 1'b1;
      if ((dram.rd_rsp_valid && !rsp_ok) || (rsp_ok && full)) err_rsp <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      // Output register freezes with the sort pipeline when not enabled.
      if (en) begin
        ldq_data_valid <= !empty;
        if (!empty) begin
          ldq_data <= mem[rd_ptr[LOG_DEPTH-1:0]];
          rd_ptr   <= rd_ptr + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[LOG_DEPTH-1:0]] <= dram.rd_rsp_data;
  end
endmodule

// File: tb/tb_ldq_dram_fetch.sv
// Bench for ldq_dram_fetch: DRAM latency model plus a queue-based reference of
// the expected request addresses and delivered lines per job.
`timescale 1ns/1ps
module tb_ldq_dram_fetch;
  localparam int W = 64, AW = 32, LW = 24, DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_b = 1'b0, start = 1'b0;
  logic          unit_en = 1'b1, mode = 1'b1, rdy = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_lines = '0;
  logic          ldq_data_valid, busy, done, err_rsp;
  logic [W-1:0]  ldq_data;
  logic          dram_vld = 1'b0, spur_vld = 1'b0;
  logic [W-1:0]  dram_data = '0;

  ldq_dram_fetch_if #(.ADDR_WIDTH(AW), .LDQ_DATA_WIDTH(W)) bus ();
  assign bus.rd_rsp_valid = dram_vld | spur_vld;
  assign bus.rd_rsp_data  = dram_data;
  assign bus.rd_req_ready = rdy;

  ldq_dram_fetch #(.LDQ_DATA_WIDTH(W), .DEPTH(DEPTH), .LOG_DEPTH(4),
                   .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_b(rst_b), .unit_en(unit_en), .mode(mode), .start(start),
    .base_addr(base_addr), .num_lines(num_lines), .dram(bus),
    .ldq_data_valid(ldq_data_valid), .ldq_data(ldq_data),
    .busy(busy), .done(done), .err_rsp(err_rsp));

  int n_pass = 0, n_tot = 0;
  int en_ctl = 0, rdy_ctl = 0, lat = 3, tog = 0, cyc = 0, hold_viol = 0;
  logic [31:0]   seed = 32'h1234_5678;
  bit            en_next = 1'b0, en_edge = 1'b0, prev_rst = 1'b0;
  logic          pv = 1'b0;
  logic [W-1:0]  pd = '0;
  logic          rv1;
  logic [AW-1:0] ra1;
  logic [AW-1:0] req_log[$], pend_addr[$];
  int            req_cyc[$], pend_due[$];
  logic [W-1:0]  got[$];

  // Line content the DRAM model returns for an address in the current job.
  function automatic logic [W-1:0] line_of(logic [AW-1:0] a);
    return {a ^ seed, a * 32'h9E37_79B1 + seed};
  endfunction

  function automatic int line_errs(logic [AW-1:0] b, int n);
    int e = 0;
    if (got.size() != n) e++;
    for (int i = 0; i < n && i < got.size(); i++)
      if (got[i] !== line_of(b + AW'(i))) e++;
    return e;
  endfunction

  function automatic int req_errs(logic [AW-1:0] b, int n);
    int e = 0;
    if (req_log.size() != n) e++;
    for (int i = 0; i < n && i < req_log.size(); i++)
      if (req_log[i] !== b + AW'(i)) e++;
    return e;
  endfunction

  // Per-cycle enable/ready drivers, changed shortly after each edge.
  always @(posedge clk) begin
    #1;
    tog++;
    case (en_ctl)
      0:       begin mode = 1'b1; unit_en = 1'b1; end
      1:       begin mode = 1'b1; unit_en = (((tog / 2) % 2) == 0); end
      2:       begin mode = (($urandom % 4) != 0); unit_en = (($urandom % 4) != 0); end
      default: begin mode = 1'b1; unit_en = 1'b0; end
    endcase
    case (rdy_ctl)
      0:       rdy = 1'b1;
      1:       rdy = 1'b0;
      default: rdy = (($urandom % 2) != 0);
    endcase
  end

  // DRAM latency model and output monitor.
  always @(negedge clk) begin
    cyc++;
    en_edge = en_next;
    en_next = mode && unit_en;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      dram_vld  = 1'b1;
      dram_data = line_of(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      dram_vld = 1'b0;
    end
    if (rst_b && bus.rd_req_valid && rdy) begin
      req_log.push_back(bus.rd_req_addr);
      req_cyc.push_back(cyc);
      pend_addr.push_back(bus.rd_req_addr);
      pend_due.push_back(cyc + lat);
    end
    if (rst_b && en_edge && ldq_data_valid) got.push_back(ldq_data);
    if (rst_b && prev_rst && !en_edge && (ldq_data_valid !== pv || ldq_data !== pd))
      hold_viol++;
    pv = ldq_data_valid;
    pd = ldq_data;
    prev_rst = rst_b;
  end

  task automatic start_job(input logic [AW-1:0] b, input int n, input int l);
    lat  = l;
    seed = $urandom;
    req_log.delete(); req_cyc.delete(); got.delete();
    @(posedge clk); #2;
    start = 1'b1; base_addr = b; num_lines = LW'(n);
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk); #1;
    rv1 = bus.rd_req_valid;
    ra1 = bus.rd_req_addr;
  endtask

  task automatic wait_done(input int bound, output bit to);
    to = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (done) begin to = 1'b0; break; end
    end
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (pend_addr.size() == 0 && !busy) break;
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2 rst_b = 1'b1;
    @(negedge clk); #1;
    n_tot++; if (bus.rd_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", bus.rd_req_valid); else n_pass++;
    n_tot++; if (bus.rd_req_addr !== '0) $display("FAIL reset_req_addr: got %h want 0", bus.rd_req_addr); else n_pass++;
    n_tot++; if (ldq_data_valid !== 1'b0) $display("FAIL reset_ldq_valid: got %b want 0", ldq_data_valid); else n_pass++;
    n_tot++; if (ldq_data !== '0) $display("FAIL reset_ldq_data: got %h want 0", ldq_data); else n_pass++;
    n_tot++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_tot++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_tot++; if (err_rsp !== 1'b0) $display("FAIL reset_err: got %b want 0", err_rsp); else n_pass++;
  endtask

  task automatic test_basic();
    bit to;
    en_ctl = 0; rdy_ctl = 0;
    start_job(32'h100, 4, 3);
    n_tot++; if ({rv1, ra1} !== {1'b1, 32'h100}) $display("FAIL basic_first_req: got v=%b a=%h want v=1 a=100", rv1, ra1); else n_pass++;
    wait_done(200, to);
    n_tot++; if (to !== 1'b0) $display("FAIL basic_timeout: got done=%b want 1", done); else n_pass++;
    n_tot++; if (req_errs(32'h100, 4) !== 0) $display("FAIL basic_reqs: got %0d reqs want 4 at 0x100..0x103", req_log.size()); else n_pass++;
    n_tot++; if (req_cyc.size() != 4 || req_cyc[3] - req_cyc[0] != 3) $display("FAIL basic_consecutive: got %0d reqs spanning non-consecutive cycles want 4 back to back", req_cyc.size()); else n_pass++;
    n_tot++; if (line_errs(32'h100, 4) !== 0) $display("FAIL basic_lines: got %0d lines want 4 in order", got.size()); else n_pass++;
    n_tot++; if (err_rsp !== 1'b0) $display("FAIL basic_err: got %b want 0", err_rsp); else n_pass++;
    n_tot++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_zero();
    en_ctl = 0; rdy_ctl = 0;
    start_job(32'h4000, 0, 3);
    n_tot++; if ({rv1, done} !== 2'b00) $display("FAIL zero_first_edge: got req=%b done=%b want 0 0", rv1, done); else n_pass++;
    @(negedge clk); #1;
    n_tot++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    n_tot++; if (req_log.size() !== 0) $display("FAIL zero_reqs: got %0d want 0", req_log.size()); else n_pass++;
    n_tot++; if (done !== 1'b1) $display("FAIL zero_done_sticky: got %b want 1", done); else n_pass++;
  endtask

  task automatic test_credit();
    bit to;
    logic [AW-1:0] b = 32'hFFFF_FFF8;
    en_ctl = 3; rdy_ctl = 0;
    start_job(b, 40, 3);
    repeat (29) @(negedge clk);
    #1;
    n_tot++; if (req_log.size() !== DEPTH) $display("FAIL credit_req_count: got %0d want %0d", req_log.size(), DEPTH); else n_pass++;
    n_tot++; if (bus.rd_req_valid !== 1'b0) $display("FAIL credit_req_valid: got %b want 0", bus.rd_req_valid); else n_pass++;
    en_ctl = 0;
    wait_done(500, to);
    n_tot++; if (to !== 1'b0) $display("FAIL credit_timeout: got done=%b want 1", done); else n_pass++;
    n_tot++; if (line_errs(b, 40) + req_errs(b, 40) !== 0) $display("FAIL credit_lines: got %0d lines %0d reqs want 40 each", got.size(), req_log.size()); else n_pass++;
    n_tot++; if (err_rsp !== 1'b0) $display("FAIL credit_err: got %b want 0", err_rsp); else n_pass++;
  endtask

  task automatic test_stall();
    bit to;
    logic [AW-1:0] b = $urandom;
    rdy_ctl = 0; en_ctl = 1;
    start_job(b, 8, 2);
    hold_viol = 0;
    wait_done(400, to);
    en_ctl = 0;
    n_tot++; if (to !== 1'b0) $display("FAIL stall_timeout: got done=%b want 1", done); else n_pass++;
    n_tot++; if (line_errs(b, 8) !== 0) $display("FAIL stall_lines: got %0d lines want 8 in order", got.size()); else n_pass++;
    n_tot++; if (hold_viol !== 0) $display("FAIL stall_hold: got %0d changes while disabled want 0", hold_viol); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit to;
    bit stable = 1'b1;
    logic [AW-1:0] b = $urandom;
    en_ctl = 0; rdy_ctl = 1;
    start_job(b, 3, 4);
    if (!(rv1 === 1'b1 && ra1 === b)) stable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (!(bus.rd_req_valid === 1'b1 && bus.rd_req_addr === b)) stable = 1'b0;
    end
    rdy_ctl = 0;
    wait_done(200, to);
    n_tot++; if (stable !== 1'b1) $display("FAIL bp_addr_stable: got unstable addr/valid want %h held", b); else n_pass++;
    n_tot++; if (to !== 1'b0) $display("FAIL bp_timeout: got done=%b want 1", done); else n_pass++;
    n_tot++; if (req_errs(b, 3) !== 0) $display("FAIL bp_reqs: got %0d handshakes want 3", req_log.size()); else n_pass++;
    n_tot++; if (line_errs(b, 3) !== 0) $display("FAIL bp_lines: got %0d lines want 3", got.size()); else n_pass++;
  endtask

  task automatic test_random();
    bit to;
    for (int k = 0; k < 6; k++) begin
      logic [AW-1:0] b = $urandom;
      int n = $urandom_range(1, 50);
      en_ctl = 2; rdy_ctl = 2;
      start_job(b, n, $urandom_range(1, 12));
      wait_done(3000, to);
      en_ctl = 0; rdy_ctl = 0;
      n_tot++; if (to !== 1'b0) $display("FAIL rand%0d_timeout: got done=%b want 1", k, done); else n_pass++;
      n_tot++; if (line_errs(b, n) + req_errs(b, n) !== 0) $display("FAIL rand%0d_stream: got %0d lines %0d reqs want %0d each", k, got.size(), req_log.size(), n); else n_pass++;
      n_tot++; if (err_rsp !== 1'b0) $display("FAIL rand%0d_err: got %b want 0", k, err_rsp); else n_pass++;
      wait_quiet();
    end
  endtask

  task automatic test_error_reset();
    bit to;
    logic [AW-1:0] b;
    @(posedge clk); #2 spur_vld = 1'b1;
    @(posedge clk); #2 spur_vld = 1'b0;
    @(negedge clk); #1;
    n_tot++; if (err_rsp !== 1'b1) $display("FAIL err_spurious: got %b want 1", err_rsp); else n_pass++;
    repeat (5) @(negedge clk);
    #1;
    n_tot++; if (err_rsp !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_rsp); else n_pass++;
    start_job($urandom, 20, 5);
    repeat (6) @(negedge clk);
    @(posedge clk); #2 rst_b = 1'b0;
    #1;
    n_tot++; if ({bus.rd_req_valid, ldq_data_valid, busy, done, err_rsp} !== 5'b0) $display("FAIL async_reset_flags: got %b want 00000", {bus.rd_req_valid, ldq_data_valid, busy, done, err_rsp}); else n_pass++;
    n_tot++; if ({bus.rd_req_addr, ldq_data} !== '0) $display("FAIL async_reset_data: got addr=%h data=%h want 0", bus.rd_req_addr, ldq_data); else n_pass++;
    @(posedge clk); #2 rst_b = 1'b1;
    wait_quiet();
    n_tot++; if (err_rsp !== 1'b1) $display("FAIL err_after_reset: got %b want 1", err_rsp); else n_pass++;
    @(posedge clk); #2 rst_b = 1'b0;
    @(posedge clk); #2 rst_b = 1'b1;
    b = $urandom;
    start_job(b, 5, 3);
    wait_done(200, to);
    n_tot++; if (to !== 1'b0 || line_errs(b, 5) !== 0) $display("FAIL post_reset_job: got %0d lines done=%b want 5 lines done=1", got.size(), done); else n_pass++;
    n_tot++; if (err_rsp !== 1'b0) $display("FAIL post_reset_err: got %b want 0", err_rsp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();        wait_quiet();
    test_zero();         wait_quiet();
    test_credit();       wait_quiet();
    test_stall();        wait_quiet();
    test_backpressure(); wait_quiet();
    test_random();
    test_error_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
